// File: rtl/shift_acc.sv
// Bit-serial shift accumulator: folds one signed partial sum per input
// bit-plane (sign plane first) into a two's-complement MAC result and hands
// it downstream through a valid/ready output register.
module shift_acc #(
   parameter int unsigned PSUM_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_acc,
   input  logic                  inwidth,
   input  logic                  psum_valid,
   input  logic [PSUM_WIDTH-1:0] psum,
   output logic                  res_valid,
   output logic [ACC_WIDTH-1:0]  res_data,
   input  logic                  res_ready,
   output logic                  busy,
   output logic                  err,
   input  logic                  err_clr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   n24_q, n24_d;
   logic [4:0]             k_q, k_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   res_valid_q, res_valid_d;
   logic [ACC_WIDTH-1:0]   res_data_q, res_data_d;
   logic                   err_q, err_d;

   logic [ACC_WIDTH-1:0]   p_ext;
   logic [ACC_WIDTH-1:0]   acc_next;
   logic                   beat;
   logic                   last;
   logic                   drain;
   logic                   err_set;

   assign p_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};

   // Next-state, datapath and output-register control
   always_comb begin
      state_d     = state_q;
      n24_d       = n24_q;
      k_d         = k_q;
      acc_d       = acc_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;

      drain    = res_valid_q & res_ready;
      beat     = (state_q == ACCUM) & psum_valid & ~start_acc;
      last     = (k_q == (n24_q ? 5'd23 : 5'd11));
      acc_next = (k_q == 5'd0) ? ('0 - p_ext) : ((acc_q << 1) + p_ext);

      err_set = (start_acc & (state_q != IDLE))
              | (psum_valid & (state_q != ACCUM))
              | (psum_valid & start_acc);

      if (drain) res_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_acc) begin
               n24_d   = inwidth;
               k_d     = '0;
               acc_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_d = acc_next;
               k_d   = k_q + 5'd1;
               if (last) begin
                  k_d = '0;
                  if (!res_valid_q || drain) begin
                     res_data_d  = acc_next;
                     res_valid_d = 1'b1;
                     state_d     = IDLE;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (drain) begin
               res_data_d  = acc_q;
               res_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         n24_q       <= 1'b0;
         k_q         <= '0;
         acc_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         n24_q       <= n24_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         err_q       <= err_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_shift_acc.sv
// Directed bench for shift_acc: table of full accumulations plus hand-written
// sequences for gaps, backpressure, protocol errors and mid-run reset.
module tb_shift_acc;

   localparam int PW = 16;
   localparam int AW = 48;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_acc;
   logic          inwidth;
   logic          psum_valid;
   logic [PW-1:0] psum;
   logic          res_valid;
   logic [AW-1:0] res_data;
   logic          res_ready;
   logic          busy;
   logic          err;
   logic          err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   shift_acc #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_acc  (start_acc),
      .inwidth    (inwidth),
      .psum_valid (psum_valid),
      .psum       (psum),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .busy       (busy),
      .err        (err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                 inw;
      logic [23:0][PW-1:0]  ps;
      logic signed [AW-1:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
                  $signed(act), act, $signed(exp), exp);
      end
   endtask

   // Start an op, then feed beats with an optional gap inserted after beat gap_at
   task automatic run_op(input logic inw, input logic [23:0][PW-1:0] ps,
                         input int gap_at, input int gap_len);
      int n;
      n = inw ? 24 : 12;
      start_acc = 1'b1; inwidth = inw;
      tick();
      start_acc = 1'b0;
      for (int b = 0; b < n; b++) begin
         psum_valid = 1'b1; psum = ps[b];
         tick();
         if (b == gap_at) begin
            psum_valid = 1'b0;
            for (int g = 0; g < gap_len; g++) tick();
         end
      end
      psum_valid = 1'b0; psum = '0;
   endtask

   logic [23:0][PW-1:0] ones, zeros;

   initial begin
      rst_n = 1'b0; start_acc = 1'b0; inwidth = 1'b0; psum_valid = 1'b0;
      psum = '0; res_ready = 1'b1; err_clr = 1'b0;
      for (int j = 0; j < 24; j++) begin ones[j] = 16'd1; zeros[j] = '0; end

      vecs[0].inw = 1'b0; vecs[0].ps = ones; vecs[0].exp = -48'sd1;
      vecs[1].inw = 1'b0; vecs[1].ps = zeros; vecs[1].ps[0] = 16'd3; vecs[1].exp = -48'sd6144;
      vecs[2].inw = 1'b1; vecs[2].ps = zeros; vecs[2].ps[23] = 16'd5; vecs[2].exp = 48'sd5;
      vecs[3].inw = 1'b1; vecs[3].ps = zeros; vecs[3].ps[0] = 16'hFFFF; vecs[3].exp = 48'sd8388608;
      vecs[4].inw = 1'b1; vecs[4].ps = ones; vecs[4].exp = -48'sd1;
      vecs[5].inw = 1'b0; vecs[5].ps = zeros; vecs[5].ps[0] = -16'sd100; vecs[5].ps[11] = 16'd7;
      vecs[5].exp = 48'sd204807;
      vecs[6].inw = 1'b0;
      for (int j = 0; j < 24; j++) vecs[6].ps[j] = 16'h7FFF;
      vecs[6].exp = -48'sd32767;

      tick(); tick();
      chk("reset_res_valid", {47'd0, res_valid}, '0);
      chk("reset_res_data", res_data, '0);
      chk("reset_busy", {47'd0, busy}, '0);
      chk("reset_err", {47'd0, err}, '0);
      rst_n = 1'b1;
      tick();

      // busy rises the cycle after start
      start_acc = 1'b1; inwidth = 1'b0;
      tick();
      start_acc = 1'b0;
      chk("busy_after_start", {47'd0, busy}, 48'd1);
      for (int b = 0; b < 12; b++) begin psum_valid = 1'b1; psum = 16'd1; tick(); end
      psum_valid = 1'b0;
      chk("first_res_valid_L1", {47'd0, res_valid}, 48'd1);
      chk("first_busy_L1", {47'd0, busy}, '0);
      chk("first_res_data", res_data, -48'sd1);
      tick();
      chk("first_drained", {47'd0, res_valid}, '0);

      // Table of full accumulations
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].inw, vecs[i].ps, -1, 0);
         chk($sformatf("vec%0d_valid", i), {47'd0, res_valid}, 48'd1);
         chk($sformatf("vec%0d_busy", i), {47'd0, busy}, '0);
         chk($sformatf("vec%0d_data", i), res_data, vecs[i].exp);
         tick();
      end
      chk("table_no_err", {47'd0, err}, '0);

      // Gap tolerance: 3 idle cycles after beat 5
      run_op(1'b0, ones, 5, 3);
      chk("gap_valid", {47'd0, res_valid}, 48'd1);
      chk("gap_data", res_data, -48'sd1);
      tick();

      // Backpressure and HOLD
      res_ready = 1'b0;
      run_op(1'b0, ones, -1, 0);
      chk("bp_op1_valid", {47'd0, res_valid}, 48'd1);
      chk("bp_op1_data", res_data, -48'sd1);
      run_op(1'b0, zeros, -1, 0);
      chk("bp_hold_busy", {47'd0, busy}, 48'd1);
      chk("bp_hold_data", res_data, -48'sd1);
      chk("bp_hold_valid", {47'd0, res_valid}, 48'd1);
      tick();
      chk("bp_hold_stable", res_data, -48'sd1);
      res_ready = 1'b1;
      tick();
      chk("bp_reload_data", res_data, '0);
      chk("bp_reload_valid", {47'd0, res_valid}, 48'd1);
      chk("bp_reload_busy", {47'd0, busy}, '0);
      tick();
      chk("bp_final_drain", {47'd0, res_valid}, '0);

      // start_acc while busy: flagged and ignored
      start_acc = 1'b1; inwidth = 1'b0; tick(); start_acc = 1'b0;
      for (int b = 0; b < 12; b++) begin
         if (b == 3) begin start_acc = 1'b1; inwidth = 1'b1; tick(); start_acc = 1'b0; end
         psum_valid = 1'b1; psum = 16'd1; tick();
      end
      psum_valid = 1'b0;
      chk("err_start_busy", {47'd0, err}, 48'd1);
      chk("err_start_busy_data", res_data, -48'sd1);
      chk("err_start_busy_valid", {47'd0, res_valid}, 48'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("err_cleared", {47'd0, err}, '0);

      // psum_valid in IDLE
      psum_valid = 1'b1; psum = 16'd9; tick(); psum_valid = 1'b0;
      chk("err_psum_idle", {47'd0, err}, 48'd1);
      chk("err_psum_idle_nobusy", {47'd0, busy}, '0);
      err_clr = 1'b1; tick();
      chk("err_clr1", {47'd0, err}, '0);
      tick();
      chk("err_clr_noerr", {47'd0, err}, '0);
      psum_valid = 1'b1; tick(); psum_valid = 1'b0; err_clr = 1'b0;
      chk("err_clr_vs_new", {47'd0, err}, 48'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // Coincident start_acc + psum_valid: start accepted, beat ignored
      start_acc = 1'b1; psum_valid = 1'b1; psum = 16'd50; inwidth = 1'b0; tick();
      start_acc = 1'b0;
      chk("err_coincident", {47'd0, err}, 48'd1);
      chk("coincident_busy", {47'd0, busy}, 48'd1);
      for (int b = 0; b < 12; b++) begin psum_valid = 1'b1; psum = 16'd1; tick(); end
      psum_valid = 1'b0;
      chk("coincident_data", res_data, -48'sd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // Reset mid-run at beat 6
      res_ready = 1'b0;
      start_acc = 1'b1; inwidth = 1'b0; tick(); start_acc = 1'b0;
      for (int b = 0; b < 6; b++) begin psum_valid = 1'b1; psum = 16'd1; tick(); end
      rst_n = 1'b0; tick(); rst_n = 1'b1; psum_valid = 1'b0; res_ready = 1'b1;
      chk("mid_rst_valid", {47'd0, res_valid}, '0);
      chk("mid_rst_data", res_data, '0);
      chk("mid_rst_busy", {47'd0, busy}, '0);
      chk("mid_rst_err", {47'd0, err}, '0);
      run_op(1'b0, ones, -1, 0);
      chk("post_rst_valid", {47'd0, res_valid}, 48'd1);
      chk("post_rst_data", res_data, -48'sd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_acc.md
# shift_acc

Bit-serial shift accumulator that receives per-cycle partial sums from the macro adder tree and turns them into signed multi-bit MAC results. It is the consumer end of the global controller's accumulate protocol. A `start_acc` pulse arms a new accumulation, and one `psum` beat arrives per input bit-plane, MSB plane first. After the last plane, the finished result is handed downstream through a valid/ready output register. A hold state absorbs downstream backpressure.

## Interface
- `PSUM_WIDTH`, 16, width of the signed adder-tree partial sum.
- `ACC_WIDTH`, 48, width of the accumulator and result; must be ≥ `PSUM_WIDTH`+24.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_acc` in 1: single-cycle pulse that arms an accumulation and samples `inwidth`.
- `inwidth` in 1: input precision; 0 = 12 planes, 1 = 24 planes.
- `psum_valid` in 1: a partial-sum beat is present.
- `psum` in `PSUM_WIDTH`: signed partial sum for the current plane.
- `res_valid` out 1: output register holds a result.
- `res_data` out `ACC_WIDTH`: signed result.
- `res_ready` in 1: downstream accepts the result.
- `busy` out 1: high in ACCUM and HOLD.
- `err` out 1: sticky protocol-error flag.
- `err_clr` in 1: clears `err`.

## Operation
- **States**
  - IDLE → ACCUM on `start_acc`.
  - ACCUM → IDLE, or ACCUM → HOLD, on the last beat.
  - HOLD → IDLE on drain.
- **On `start_acc` in IDLE**
  - Latch N = 12 or 24 from `inwidth`.
  - Beat counter k = 0; accumulator = 0.
  - A `psum_valid` beat in that same cycle is ignored and sets `err`.
- **ACCUM, each `psum_valid` beat k**, with p = sign-extended `psum`
  - k = 0: acc ← −p.
  - k > 0: acc ← (acc << 1) + p.
  - k increments after each beat.
  - Result = Σ psum_k·w_k, where w_0 = −2^(N−1) and w_k = 2^(N−1−k). This is two's-complement input with the sign plane first.
  - Gaps (`psum_valid` = 0) are allowed and leave acc and k unchanged.
- **Last beat (k = N−1), completion**
  - If the output register is free, or draining that cycle (`res_valid`&`res_ready`): load `res_data` ← final acc, set `res_valid`, go to IDLE.
  - Otherwise: go to HOLD with the final value kept in acc.
- **HOLD**
  - On `res_valid`&`res_ready`, `res_data` reloads from acc in the same edge; `res_valid` stays 1 and the state goes to IDLE.
- **Output register**
  - `res_valid` clears on `res_ready` when no new result loads in that edge.
  - `res_data` is stable while `res_valid`&!`res_ready`.
- **Arithmetic**
  - Full `ACC_WIDTH` two's complement; wraps on overflow, which cannot occur within the width rule.
- **`err` sources** (the offending event is ignored, with no state change)
  - `start_acc` while `busy`.
  - `psum_valid` in IDLE or HOLD.
  - `psum_valid` coincident with `start_acc`.
- **`err` clearing**
  - `err_clr` clears `err`, but a new error in the same cycle wins and `err` stays 1.

## Timing
- **Reset values**
  - State IDLE; `busy` = 0; `res_valid` = 0; `res_data` = 0; `err` = 0.
  - Internal acc and k are 0.
- **Reset mid-operation**
  - Discards the accumulation and any pending result.
- `busy` rises the cycle after `start_acc`.
- **Last beat at cycle L**
  - `res_valid` = 1 and `busy` = 0 from L+1 if the output register is free.
  - Otherwise HOLD; `busy` falls the cycle after the drain.
- **Back-to-back operation**
  - `start_acc` is accepted at L+1 while `res_valid` is still 1.
  - Minimum op period is N+1 cycles.
- Latency from `start_acc` with no gaps and a free output is N+1 cycles.

## Test plan
- **Sign-plane weighting:** `inwidth`=0, `start_acc`, then 12 consecutive beats of `psum`=1 → `res_data`=−1 (2048 subtracted, 2047 added); `res_valid` at L+1; `busy` 0 at L+1.
- **MSB plane only:** `inwidth`=0, beats 3,0,…,0 → −6144. Then `inwidth`=1, beats 0×23 followed by 5 → 5. Then `inwidth`=1, beat 0 = −1 followed by 23 beats of 0 → +8388608.
- **Gap tolerance:** 12-plane run with `psum_valid` dropped for 3 cycles mid-stream, `psum`=1 on every beat → still −1, completion delayed by 3 cycles.
- **Backpressure:** `res_ready`=0, first op completes (−1) and a second op (all-zero psum) completes → second enters HOLD with `busy`=1 and `res_data` stays −1. Raise `res_ready` → next cycle `res_data`=0 with `res_valid`=1, `busy`=0.
- **Protocol errors:** `start_acc` while `busy` → `err`=1 and the accumulation result is unchanged. `psum_valid` in IDLE → `err`=1. `err_clr` with no error → `err`=0. `err_clr` coincident with a new error → `err`=1.
- **Reset mid-run:** `rst_n`=0 for one cycle at beat 6 → all outputs 0. A fresh run of 12 beats of 1 then yields −1.
